// File: rtl/dram_arbiter_pkg.sv
// Shared types and constants for the multi-core data RAM arbiter.
package dram_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    // Read latency counter is sized for the largest supported RD_LAT.
    localparam int MAX_RD_LAT = 255;
    localparam int CNT_W      = $clog2(MAX_RD_LAT + 1);

    localparam int DEFAULT_N_CORES = 4;
    localparam int PTR_RST_DEFAULT = DEFAULT_N_CORES - 1;

endpackage

// File: rtl/dram_arbiter_picker.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_priority_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_index
);

    logic [IW-1:0] w_cand [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_cand
        assign w_cand[gi] = IW'((int'(i_ptr) + gi + 1) % N);
    end

    // Walk from the farthest candidate back so the nearest one after ptr wins.
    always_comb begin
        o_onehot = '0;
        o_index  = '0;
        for (int off = N - 1; off >= 0; off--) begin
            if (i_req[w_cand[off]]) begin
                o_onehot              = '0;
                o_onehot[w_cand[off]] = 1'b1;
                o_index               = w_cand[off];
            end
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Serialises per-core read/write requests onto one RAM port, steers read data
// back with a one-cycle ack, and gathers core_done pulses into all_done.
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int N_CORES = DEFAULT_N_CORES,
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int RD_LAT  = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CORES-1:0]    req,
    input  logic [N_CORES-1:0]    wr,
    input  logic [N_CORES*AW-1:0] addr,
    input  logic [N_CORES*DW-1:0] wdata,
    output logic [N_CORES-1:0]    ack,
    output logic [DW-1:0]         rdata,
    output logic [N_CORES-1:0]    gnt,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    output logic                  mem_wren,
    input  logic [DW-1:0]         mem_rdata,
    input  logic [N_CORES-1:0]    core_done,
    output logic                  all_done
);

    localparam int PW = $clog2(N_CORES);
    // Pointer starts on the last core so core 0 wins the first arbitration.
    localparam int PTR_RST = PTR_RST_DEFAULT - DEFAULT_N_CORES + N_CORES;

    state_t               r_state, w_state_next;
    logic [PW-1:0]        r_ptr;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_wr_q;
    logic [N_CORES-1:0]   r_gnt, r_ack, r_done_q;
    logic [DW-1:0]        r_rdata, r_mem_wdata;
    logic [AW-1:0]        r_mem_addr;
    logic                 r_mem_wren, r_all_done;

    logic [N_CORES-1:0]   w_win_oh;
    logic [PW-1:0]        w_win_idx;
    logic [AW-1:0]        w_win_addr;
    logic [DW-1:0]        w_win_wdata;

    rr_priority_picker #(
        .N  (N_CORES),
        .IW (PW)
    ) u_picker (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_onehot (w_win_oh),
        .o_index  (w_win_idx)
    );

    assign w_win_addr  = addr[w_win_idx*AW +: AW];
    assign w_win_wdata = wdata[w_win_idx*DW +: DW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (|req) w_state_next = ISSUE;
            ISSUE:   w_state_next = r_wr_q ? RESP : WAIT;
            WAIT:    if (r_cnt == CNT_W'(1)) w_state_next = RESP;
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= PW'(PTR_RST);
            r_cnt       <= '0;
            r_wr_q      <= 1'b0;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wren  <= 1'b0;
        end else begin
            r_ack      <= '0;
            r_mem_wren <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Inputs are sampled only here; later changes are ignored.
                    if (|req) begin
                        r_mem_addr  <= w_win_addr;
                        r_mem_wdata <= w_win_wdata;
                        r_wr_q      <= wr[w_win_idx];
                        r_mem_wren  <= wr[w_win_idx];
                        r_gnt       <= w_win_oh;
                        r_ptr       <= w_win_idx;
                    end
                end
                ISSUE: begin
                    if (r_wr_q) r_ack <= r_gnt;
                    else        r_cnt <= CNT_W'(RD_LAT);
                end
                WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_rdata <= mem_rdata;
                        r_ack   <= r_gnt;
                    end
                end
                RESP:    r_gnt <= '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done_q   <= '0;
            r_all_done <= 1'b0;
        end else begin
            r_done_q   <= r_done_q | core_done;
            r_all_done <= &r_done_q;
        end
    end

    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign gnt       = r_gnt;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wren  = r_mem_wren;
    assign all_done  = r_all_done;

endmodule
